// File: rtl/cpu_types.sv
// Shared CPU types: write-back select, load funct3 codes and the
// control bundle carried into the write-back stage.
package cpu_types;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic    reg_write;
        wb_sel_t wb_sel;
    } ctrl_t;

endpackage

// File: rtl/load_extend.sv
// Load lane selection, sign/zero extension and misalignment flag.
// Purely combinational; off is the low two bits of the load address.
module load_extend
    import cpu_types::*;
(
    input  wb_sel_t     wb_sel,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] ext,
    output logic        misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed lane and extend it according to funct3.
    always_comb begin
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = rdata[{off[1], 4'b0000} +: 16];
        unique case (funct3)
            F3_LB:   ext = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  ext = {24'h0, byte_v};
            F3_LH:   ext = {{16{half_v[15]}}, half_v};
            F3_LHU:  ext = {16'h0, half_v};
            default: ext = rdata;
        endcase
    end

    // Halfword loads need even addresses, word loads word-aligned ones.
    always_comb begin
        misaligned = 1'b0;
        if (wb_sel == WB_MEM) begin
            if ((funct3 == F3_LH || funct3 == F3_LHU) && off[0])
                misaligned = 1'b1;
            if (funct3 == F3_LW && off != 2'b00)
                misaligned = 1'b1;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and integer register file (x1..x31) with optional
// same-cycle write-to-read bypass and a retired-instruction counter.
module wb_regfile
    import cpu_types::*;
#(
    parameter int INSTRET_W = 64,
    parameter bit BYPASS    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wb_valid,
    input  ctrl_t                wb_ctrl,
    input  logic [31:0]          wb_alu_out,
    input  logic [31:0]          wb_rdata,
    input  logic [4:0]           wb_rd,
    input  logic [31:0]          wb_pc_plus4,
    input  logic [2:0]           wb_funct3,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    output logic [31:0]          id_rs1_data,
    output logic [31:0]          id_rs2_data,
    output logic [31:0]          wb_result,
    output logic                 wb_misaligned,
    output logic [INSTRET_W-1:0] instret
);

    logic [31:0]          load_ext;
    logic                 load_mis;
    logic                 we;
    logic [31:0]          regs_q [31:1];
    logic [31:0]          regs_d [31:1];
    logic [INSTRET_W-1:0] instret_q;
    logic [INSTRET_W-1:0] instret_d;
    logic [31:0]          rs1_raw;
    logic [31:0]          rs2_raw;

    load_extend u_load_extend (
        .wb_sel     (wb_ctrl.wb_sel),
        .funct3     (wb_funct3),
        .off        (wb_alu_out[1:0]),
        .rdata      (wb_rdata),
        .ext        (load_ext),
        .misaligned (load_mis)
    );

    assign wb_misaligned = load_mis;

    // Select the value being written back; unknown selects fall to ALU.
    always_comb begin
        unique case (wb_ctrl.wb_sel)
            WB_MEM:  wb_result = load_ext;
            WB_PC4:  wb_result = wb_pc_plus4;
            default: wb_result = wb_alu_out;
        endcase
    end

    // A misaligned load retires but must not corrupt its destination.
    assign we = wb_valid & wb_ctrl.reg_write
              & (wb_rd != 5'd0) & ~load_mis;

    // Next register and counter state.
    always_comb begin
        for (int i = 1; i < 32; i++)
            regs_d[i] = (we && wb_rd == 5'(i)) ? wb_result : regs_q[i];
        instret_d = wb_valid ? instret_q + 1'b1 : instret_q;
    end

    // State registers, cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q    <= '{default: '0};
            instret_q <= '0;
        end else begin
            regs_q    <= regs_d;
            instret_q <= instret_d;
        end
    end

    // Zero-latency read muxes; index 0 never matches, so x0 reads 0.
    always_comb begin
        rs1_raw = '0;
        rs2_raw = '0;
        for (int i = 1; i < 32; i++) begin
            if (id_rs1 == 5'(i)) rs1_raw = regs_q[i];
            if (id_rs2 == 5'(i)) rs2_raw = regs_q[i];
        end
    end

    // Forward the in-flight write to a matching read port.
    always_comb begin
        id_rs1_data = rs1_raw;
        id_rs2_data = rs2_raw;
        if (BYPASS && we && id_rs1 == wb_rd) id_rs1_data = wb_result;
        if (BYPASS && we && id_rs2 == wb_rd) id_rs2_data = wb_result;
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: vector table with a scoreboard
// queue, plus hand sequences for reset, counting and wrap.
module tb_wb_regfile;
    import cpu_types::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    ctrl_t       wb_ctrl;
    logic [31:0] wb_alu_out, wb_rdata, wb_pc_plus4;
    logic [4:0]  wb_rd, id_rs1, id_rs2;
    logic [2:0]  wb_funct3;

    logic [31:0] b_rs1, b_rs2, b_res;
    logic        b_mis;
    logic [63:0] b_cnt;
    logic [31:0] n_rs1, n_rs2, n_res;
    logic        n_mis;
    logic [63:0] n_cnt;
    logic [31:0] w_rs1, w_rs2, w_res;
    logic        w_mis;
    logic [3:0]  w_cnt;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid),
        .wb_ctrl(wb_ctrl), .wb_alu_out(wb_alu_out),
        .wb_rdata(wb_rdata), .wb_rd(wb_rd),
        .wb_pc_plus4(wb_pc_plus4), .wb_funct3(wb_funct3),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(b_rs1), .id_rs2_data(b_rs2),
        .wb_result(b_res), .wb_misaligned(b_mis), .instret(b_cnt)
    );

    wb_regfile #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .wb_valid(wb_valid),
        .wb_ctrl(wb_ctrl), .wb_alu_out(wb_alu_out),
        .wb_rdata(wb_rdata), .wb_rd(wb_rd),
        .wb_pc_plus4(wb_pc_plus4), .wb_funct3(wb_funct3),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(n_rs1), .id_rs2_data(n_rs2),
        .wb_result(n_res), .wb_misaligned(n_mis), .instret(n_cnt)
    );

    wb_regfile #(.INSTRET_W(4)) dut_w4 (
        .clk(clk), .reset(reset), .wb_valid(wb_valid),
        .wb_ctrl(wb_ctrl), .wb_alu_out(wb_alu_out),
        .wb_rdata(wb_rdata), .wb_rd(wb_rd),
        .wb_pc_plus4(wb_pc_plus4), .wb_funct3(wb_funct3),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(w_rs1), .id_rs2_data(w_rs2),
        .wb_result(w_res), .wb_misaligned(w_mis), .instret(w_cnt)
    );

    typedef struct {
        logic        valid;
        logic        rw;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e_res;
        logic        e_mis;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_rs1nb;
        logic [31:0] e_rs2nb;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        mis;
        logic [31:0] rs1, rs2, rs1nb, rs2nb;
    } exp_t;

    vec_t vec [17];
    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_valid = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic v, input logic rw, input logic [1:0] sel,
        input logic [31:0] alu, input logic [31:0] rdata,
        input logic [4:0] rd, input logic [31:0] pc4,
        input logic [2:0] f3, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [31:0] res,
        input logic mis, input logic [31:0] r1,
        input logic [31:0] r2, input logic [31:0] r1nb,
        input logic [31:0] r2nb);
        vec_t t;
        t.valid = v; t.rw = rw; t.sel = sel; t.alu = alu;
        t.rdata = rdata; t.rd = rd; t.pc4 = pc4; t.f3 = f3;
        t.rs1 = rs1; t.rs2 = rs2; t.e_res = res; t.e_mis = mis;
        t.e_rs1 = r1; t.e_rs2 = r2; t.e_rs1nb = r1nb;
        t.e_rs2nb = r2nb;
        return t;
    endfunction

    task automatic idle();
        wb_valid = 1'b0;
        wb_ctrl.reg_write = 1'b0;
        wb_ctrl.wb_sel = WB_ALU;
        wb_alu_out = '0; wb_rdata = '0; wb_rd = '0;
        wb_pc_plus4 = '0; wb_funct3 = '0;
        id_rs1 = '0; id_rs2 = '0;
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        wb_valid = v.valid;
        wb_ctrl.reg_write = v.rw;
        wb_ctrl.wb_sel = wb_sel_t'(v.sel);
        wb_alu_out = v.alu; wb_rdata = v.rdata; wb_rd = v.rd;
        wb_pc_plus4 = v.pc4; wb_funct3 = v.f3;
        id_rs1 = v.rs1; id_rs2 = v.rs2;
        e.res = v.e_res; e.mis = v.e_mis;
        e.rs1 = v.e_rs1; e.rs2 = v.e_rs2;
        e.rs1nb = v.e_rs1nb; e.rs2nb = v.e_rs2nb;
        sb.push_back(e);
    endtask

    task automatic compare(input int k);
        exp_t e;
        if (sb.size() == 0) begin
            chk($sformatf("v%0d sb_empty", k), 1, 0);
            return;
        end
        e = sb.pop_front();
        chk($sformatf("v%0d result", k), 64'(b_res), 64'(e.res));
        chk($sformatf("v%0d mis", k), 64'(b_mis), 64'(e.mis));
        chk($sformatf("v%0d rs1", k), 64'(b_rs1), 64'(e.rs1));
        chk($sformatf("v%0d rs2", k), 64'(b_rs2), 64'(e.rs2));
        chk($sformatf("v%0d nb_rs1", k), 64'(n_rs1), 64'(e.rs1nb));
        chk($sformatf("v%0d nb_rs2", k), 64'(n_rs2), 64'(e.rs2nb));
    endtask

    task automatic chk_cnt(input string nm, input int exp64,
                           input int exp4);
        chk({nm, " instret"}, b_cnt, 64'(exp64));
        chk({nm, " nb_instret"}, n_cnt, 64'(exp64));
        chk({nm, " w4_instret"}, 64'(w_cnt), 64'(exp4));
    endtask

    initial begin
        vec[0]  = mk(1,1,2'd0,32'hDEADBEEF,0,5,0,0,5,0,
                     32'hDEADBEEF,0,32'hDEADBEEF,0,0,0);
        vec[1]  = mk(1,1,2'd0,32'h11111111,0,0,0,0,5,0,
                     32'h11111111,0,32'hDEADBEEF,0,32'hDEADBEEF,0);
        vec[2]  = mk(0,0,2'd0,0,0,0,0,0,0,5,
                     0,0,0,32'hDEADBEEF,0,32'hDEADBEEF);
        vec[3]  = mk(1,1,2'd1,3,32'h80FF7F01,10,0,F3_LB,10,5,
                     32'hFFFFFF80,0,32'hFFFFFF80,32'hDEADBEEF,
                     0,32'hDEADBEEF);
        vec[4]  = mk(1,1,2'd1,1,32'h80FF7F01,11,0,F3_LBU,10,11,
                     32'h7F,0,32'hFFFFFF80,32'h7F,32'hFFFFFF80,0);
        vec[5]  = mk(1,1,2'd1,2,32'h80FF7F01,12,0,F3_LH,11,0,
                     32'hFFFF80FF,0,32'h7F,0,32'h7F,0);
        vec[6]  = mk(1,1,2'd1,32'h100,32'h80FF7F01,13,0,F3_LHU,12,13,
                     32'h7F01,0,32'hFFFF80FF,32'h7F01,32'hFFFF80FF,0);
        vec[7]  = mk(1,1,2'd1,32'h1002,32'h80FF7F01,5,0,F3_LW,5,13,
                     32'h80FF7F01,1,32'hDEADBEEF,32'h7F01,
                     32'hDEADBEEF,32'h7F01);
        vec[8]  = mk(0,0,2'd0,0,0,0,0,0,5,0,
                     0,0,32'hDEADBEEF,0,32'hDEADBEEF,0);
        vec[9]  = mk(1,1,2'd1,32'h21,32'h80FF7F01,14,0,F3_LH,14,0,
                     32'h7F01,1,0,0,0,0);
        vec[10] = mk(1,1,2'd0,32'h12345678,0,7,0,0,0,7,
                     32'h12345678,0,0,32'h12345678,0,0);
        vec[11] = mk(1,1,2'd0,32'hCAFEF00D,0,7,0,0,7,7,
                     32'hCAFEF00D,0,32'hCAFEF00D,32'hCAFEF00D,
                     32'h12345678,32'h12345678);
        vec[12] = mk(1,1,2'd2,32'hFFFF,0,1,32'h104,0,7,1,
                     32'h104,0,32'hCAFEF00D,32'h104,32'hCAFEF00D,0);
        vec[13] = mk(0,0,2'd0,0,0,0,0,0,1,0,
                     0,0,32'h104,0,32'h104,0);
        vec[14] = mk(1,0,2'd3,32'hA5A5A5A5,0,3,0,0,3,0,
                     32'hA5A5A5A5,0,0,0,0,0);
        vec[15] = mk(1,1,2'd1,32'h1000,32'h12345678,3,0,F3_LW,3,0,
                     32'h12345678,0,32'h12345678,0,0,0);
        vec[16] = mk(1,1,2'd1,3,32'h0BADF00D,4,0,3'b011,3,4,
                     32'h0BADF00D,0,32'h12345678,32'h0BADF00D,
                     32'h12345678,0);

        idle();
        reset = 1'b0;
        #1;
        chk("rst rs1", 64'(b_rs1), 0);
        chk_cnt("rst", 0, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            drive(vec[k]);
            if (vec[k].valid) n_valid++;
            #2;
            compare(k);
        end
        @(negedge clk);
        idle();
        #1;
        chk_cnt("table", n_valid, n_valid % 16);

        // 10 retiring slots and 3 bubbles after a fresh reset
        #1 reset = 1'b0;
        #1;
        chk_cnt("pulse0", 0, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            idle();
            wb_valid = (i % 4 != 3);
        end
        @(negedge clk);
        idle();
        #1;
        chk_cnt("count10", 10, 10);

        // write x9, then a mid-cycle reset must clear everything
        @(negedge clk);
        wb_valid = 1'b1; wb_ctrl.reg_write = 1'b1;
        wb_alu_out = 32'h99; wb_rd = 5'd9;
        @(negedge clk);
        idle();
        id_rs1 = 5'd9;
        #1;
        chk("x9 written", 64'(b_rs1), 64'h99);
        #2 reset = 1'b0;
        #1;
        chk_cnt("midrst", 0, 0);
        for (int i = 1; i < 32; i++) begin
            id_rs1 = 5'(i); id_rs2 = 5'(i);
            #1;
            chk($sformatf("rst x%0d p1", i), 64'(b_rs1), 0);
            chk($sformatf("rst x%0d p2", i), 64'(b_rs2), 0);
            chk($sformatf("rst nb x%0d", i), 64'(n_rs1), 0);
        end

        // writes presented during reset are bypassed but not stored
        @(negedge clk);
        wb_valid = 1'b1; wb_ctrl.reg_write = 1'b1;
        wb_alu_out = 32'h55; wb_rd = 5'd9; id_rs1 = 5'd9;
        #1;
        chk("rst bypass", 64'(b_rs1), 64'h55);
        chk("rst nb bypass", 64'(n_rs1), 0);
        @(negedge clk);
        idle();
        id_rs1 = 5'd9;
        #1;
        chk("rst discard", 64'(b_rs1), 0);
        chk_cnt("rst hold", 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // resume after reset; 17 retirements wrap the 4-bit counter
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            idle();
            wb_valid = 1'b1;
        end
        @(negedge clk);
        idle();
        #1;
        chk_cnt("wrap", 17, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
